sb_arbiter: RTL
===============

SB_ARBITER -- requirements
Module: sb_arbiter

Interface
REQ-001 SHALL have parameter CORE_MAX_WAIT, default 4: max consecutive contested debug grants before core is forced to win (range 1-15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: bus-wait cycles before abort (range 1-255, used only under REQ-025).
REQ-003 SHALL use one clock and synchronous active-high reset: clk input 1 (rising edge); reset input 1 (synchronous, active-high).
REQ-004 SHALL have debug requester ports: dbg_req in 1 (request level); dbg_we in 1 (1=write); dbg_addr in 32; dbg_wdata in 32; dbg_gnt out 1 (grant pulse); dbg_done out 1 (completion pulse); dbg_err out 1 (error, valid with done); dbg_rdata out 32 (read data, valid with done).
REQ-005 SHALL have core requester ports core_req, core_we, core_addr, core_wdata, core_gnt, core_done, core_err, core_rdata, with the same widths and meanings as REQ-004.
REQ-006 SHALL have system bus ports: sb_addr out 32; sb_wdata out 32; sb_read out 1; sb_write out 1; sb_rdata in 32; sb_ready in 1 (transfer complete).

Function
REQ-007 SHALL implement states IDLE, ACTIVE, RESP; exactly one transaction is in flight at a time.
REQ-008 IDLE: if any *_req is high, SHALL pick a winner, latch its we/addr/wdata, and enter ACTIVE next cycle; with no request, stays IDLE.
REQ-009 Arbitration: debug wins by default; core wins when only core requests, or when both request and starve_cnt == CORE_MAX_WAIT.
REQ-010 starve_cnt (4 bits) SHALL increment when debug wins while core_req is high, clear when core is granted, and saturate at CORE_MAX_WAIT.
REQ-011 Winner's *_gnt SHALL pulse high for exactly the first ACTIVE cycle; the loser sees no gnt.
REQ-012 ACTIVE: sb_read=~we or sb_write=we SHALL be held high, with sb_addr/sb_wdata held at the latched values, until sb_ready is sampled high.
REQ-013 On the ACTIVE cycle with sb_ready high, SHALL capture sb_rdata (reads) and enter RESP; sb_read/sb_write low from the next cycle.
REQ-014 RESP (one cycle): winner's *_done SHALL pulse high, *_rdata holds captured data (0 for writes), *_err=0; then IDLE.
REQ-015 Latency: req sampled at cycle 0 -> gnt and bus strobe at cycle 1 -> sb_ready at cycle k -> done at k+1 -> next arbitration at k+2.
REQ-016 Requester protocol: req, we, addr, wdata stable from req rise until done; req dropped the cycle after done; arbiter never samples req in RESP.
REQ-017 *_rdata SHALL hold its value until that requester's next done.
REQ-018 sb_ready SHALL be ignored in IDLE and RESP.
REQ-019 A requester dropping req during ACTIVE SHALL NOT abort the bus transaction; done is still issued.
REQ-020 sb_addr/sb_wdata SHALL be 0 in IDLE; sb_read and sb_write SHALL never be high together.

Reset
REQ-021 Reset SHALL force: state=IDLE, starve_cnt=0, all outputs 0 (sb_*, *_gnt, *_done, *_err, *_rdata).
REQ-022 Reset during ACTIVE or RESP SHALL abandon the transaction with no done pulse; strobes are low the cycle after reset is sampled.
REQ-023 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-024 Macro SB_TIMEOUT_EN SHALL select the bus watchdog.
REQ-025 With SB_TIMEOUT_EN: an 8-bit counter clears on entering ACTIVE and increments per ACTIVE cycle without sb_ready; at TIMEOUT_CYCLES, drop strobes and go to RESP with *_err=1, *_rdata=0; sb_ready in the same cycle wins (normal completion).
REQ-026 Without SB_TIMEOUT_EN: ACTIVE waits indefinitely, no counter exists, and *_err is tied to 0.

Verification
REQ-027 Debug read only: dbg_req, addr 0x1000, sb_ready at cycle 3 with sb_rdata 0xDEADBEEF -> dbg_gnt at cycle 1, dbg_done at cycle 4, dbg_rdata=0xDEADBEEF.
REQ-028 Both requesting continuously, CORE_MAX_WAIT=4, sb_ready 1 cycle after strobe -> grant order D,D,D,D,C,D,D,D,D,C.
REQ-029 Core write 0x55AA to 0x2000 -> sb_write=1, sb_addr=0x2000, sb_wdata=0x55AA held until sb_ready; core_done with core_err=0.
REQ-030 SB_TIMEOUT_EN, TIMEOUT_CYCLES=8, sb_ready never asserted -> strobe low after 8 ACTIVE cycles, dbg_done=1, dbg_err=1, dbg_rdata=0; repeat with sb_ready on the 8th cycle -> dbg_err=0.
REQ-031 Reset asserted in the 2nd ACTIVE cycle -> next cycle sb_read=0, no dbg_done, state IDLE, starve_cnt=0.

Source files
------------

// File: rtl/sb_arbiter.sv
// sb_arbiter: two-requester (debug, core) arbiter onto a single system bus.
// Optional bus watchdog enabled by defining SB_TIMEOUT_EN.
module sb_arbiter #(
   parameter int unsigned CORE_MAX_WAIT  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic        dbg_done,
   output logic        dbg_err,
   output logic [31:0] dbg_rdata,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic        core_gnt,
   output logic        core_done,
   output logic        core_err,
   output logic [31:0] core_rdata,
   output logic [31:0] sb_addr,
   output logic [31:0] sb_wdata,
   output logic        sb_read,
   output logic        sb_write,
   input  logic [31:0] sb_rdata,
   input  logic        sb_ready
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_RESP
   } state_e;

   localparam logic [3:0] MAX_WAIT = 4'(CORE_MAX_WAIT);

   if (CORE_MAX_WAIT == 0 || CORE_MAX_WAIT > 15) begin : g_bad_max_wait
      $error("sb_arbiter: CORE_MAX_WAIT must be 1..15");
   end

   if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("sb_arbiter: TIMEOUT_CYCLES must be 1..255");
   end

   state_e      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        own_core_q, own_core_d;
   logic        first_q, first_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] dbg_rdata_q, dbg_rdata_d;
   logic [31:0] core_rdata_q, core_rdata_d;

   logic        core_win;
   logic        capture;
   logic [31:0] cap_data;

`ifdef SB_TIMEOUT_EN
   localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
`endif

   // Next-state: arbitration in IDLE, bus completion in ACTIVE, one RESP cycle.
   always_comb begin
      state_d      = state_q;
      starve_d     = starve_q;
      own_core_d   = own_core_q;
      first_d      = 1'b0;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      dbg_rdata_d  = dbg_rdata_q;
      core_rdata_d = core_rdata_q;
      core_win     = 1'b0;
      capture      = 1'b0;
      cap_data     = '0;
`ifdef SB_TIMEOUT_EN
      cnt_d        = cnt_q;
      err_d        = err_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (dbg_req || core_req) begin
               core_win = core_req &&
                          (!dbg_req || (starve_q == MAX_WAIT));
               own_core_d = core_win;
               we_d       = core_win ? core_we    : dbg_we;
               addr_d     = core_win ? core_addr  : dbg_addr;
               wdata_d    = core_win ? core_wdata : dbg_wdata;
               first_d    = 1'b1;
               state_d    = ST_ACTIVE;
               if (core_win) begin
                  starve_d = '0;
               end else if (core_req && (starve_q < MAX_WAIT)) begin
                  starve_d = starve_q + 4'd1;
               end
`ifdef SB_TIMEOUT_EN
               cnt_d = '0;
               err_d = 1'b0;
`endif
            end
         end
         ST_ACTIVE: begin
            if (sb_ready) begin
               state_d  = ST_RESP;
               capture  = 1'b1;
               cap_data = we_q ? 32'd0 : sb_rdata;
            end
`ifdef SB_TIMEOUT_EN
            else if (cnt_q == TMO_LIM) begin
               state_d  = ST_RESP;
               capture  = 1'b1;
               cap_data = '0;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (capture) begin
         if (own_core_q) begin
            core_rdata_d = cap_data;
         end else begin
            dbg_rdata_d = cap_data;
         end
      end
   end

   // State and datapath registers; reset abandons any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         starve_q     <= '0;
         own_core_q   <= 1'b0;
         first_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         dbg_rdata_q  <= '0;
         core_rdata_q <= '0;
`ifdef SB_TIMEOUT_EN
         cnt_q        <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         starve_q     <= starve_d;
         own_core_q   <= own_core_d;
         first_q      <= first_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         dbg_rdata_q  <= dbg_rdata_d;
         core_rdata_q <= core_rdata_d;
`ifdef SB_TIMEOUT_EN
         cnt_q        <= cnt_d;
         err_q        <= err_d;
`endif
      end
   end

   // Outputs decoded from state: strobes only in ACTIVE, done only in RESP.
   always_comb begin
      sb_read    = 1'b0;
      sb_write   = 1'b0;
      sb_addr    = '0;
      sb_wdata   = '0;
      dbg_gnt    = 1'b0;
      core_gnt   = 1'b0;
      dbg_done   = 1'b0;
      core_done  = 1'b0;
      dbg_err    = 1'b0;
      core_err   = 1'b0;
      dbg_rdata  = dbg_rdata_q;
      core_rdata = core_rdata_q;
      unique case (1'b1)
         (state_q == ST_ACTIVE): begin
            sb_read  = !we_q;
            sb_write = we_q;
            sb_addr  = addr_q;
            sb_wdata = wdata_q;
            dbg_gnt  = first_q && !own_core_q;
            core_gnt = first_q && own_core_q;
         end
         (state_q == ST_RESP): begin
            dbg_done  = !own_core_q;
            core_done = own_core_q;
`ifdef SB_TIMEOUT_EN
            dbg_err   = !own_core_q && err_q;
            core_err  = own_core_q && err_q;
`endif
         end
         default: begin
         end
      endcase
   end

endmodule
